// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: first-word-fall-through FIFO with
// valid/ready output, fill level, full/empty and a sticky overrun flag.
module uart_rx_fifo #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  input  logic                    flush,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    empty,
  output logic                    overrun,
  input  logic                    clear_overrun
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [LW-1:0]         count;

  logic push;
  logic pop;
  logic overrun_set;

  always_comb begin
    full        = (count == FULL_LEVEL);
    empty       = (count == '0);
    out_valid   = !empty;
    pop         = out_valid && out_ready && !flush;
    // A full FIFO can still take a byte when the head leaves on the same edge.
    push        = in_valid && !flush && (!full || pop);
    overrun_set = in_valid && !flush && full && !pop;
    level       = count;
    out_data    = out_valid ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (overrun_set) begin
      overrun <= 1'b1;
    end else if (clear_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected bytes are queued on push and
// compared against out_data whenever the consumer takes the head byte.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          flush;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    level;
  logic          full;
  logic          empty;
  logic          overrun;
  logic          clear_overrun;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [DW-1:0] sb [$];

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .flush         (flush),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .level         (level),
    .full          (full),
    .empty         (empty),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [DW-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    sb.push_back(d);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0;
    out_ready = 1'b0; clear_overrun = 1'b0;
    sb.delete();
    step(); step();
    reset_n = 1'b1;
    step();
    tests++;
    if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: level=%0d empty=%b full=%b want 0/1/0", level, empty, full);
    end
    tests++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_out: valid=%b data=%h ovr=%b want 0/00/0", out_valid, out_data, overrun);
    end
  endtask

  task automatic test_first_word();
    logic [DW-1:0] exp;
    push_byte(8'hA5);
    tests++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || level !== 5'd1 || empty !== 1'b0) begin
      fails++;
      $display("FAIL fwft: valid=%b data=%h level=%0d empty=%b want 1/a5/1/0",
               out_valid, out_data, level, empty);
    end
    out_ready = 1'b1;
    exp = sb.pop_front();
    tests++;
    if (out_data !== exp) begin
      fails++;
      $display("FAIL fwft_pop: got %h want %h", out_data, exp);
    end
    step();
    out_ready = 1'b0;
    tests++;
    if (empty !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL fwft_empty: empty=%b valid=%b want 1/0", empty, out_valid);
    end
  endtask

  task automatic drain_check(input string name);
    logic [DW-1:0] exp;
    out_ready = 1'b1;
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      tests++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        fails++;
        $display("FAIL %s: valid=%b data=%h want 1/%h", name, out_valid, out_data, exp);
      end
      step();
    end
    out_ready = 1'b0;
    tests++;
    if (empty !== 1'b1 || out_data !== 8'h00 || level !== 5'd0) begin
      fails++;
      $display("FAIL %s_end: empty=%b data=%h level=%0d want 1/00/0", name, empty, out_data, level);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 16; i++) push_byte(8'(i));
    tests++;
    if (full !== 1'b1 || level !== 5'd16 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL fill: full=%b level=%0d ovr=%b want 1/16/0", full, level, overrun);
    end
    drain_check("drain_order");
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    in_data = 8'hEE; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    tests++;
    if (overrun !== 1'b1 || level !== 5'd16 || full !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set: ovr=%b level=%0d full=%b want 1/16/1", overrun, level, full);
    end
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    tests++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL overrun_clear: got %b want 0", overrun);
    end
    in_data = 8'hEE; in_valid = 1'b1; clear_overrun = 1'b1;
    step();
    in_valid = 1'b0; clear_overrun = 1'b0;
    tests++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set_wins: got %b want 1", overrun);
    end
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    tests++;
    if (overrun !== 1'b0 || level !== 5'd16) begin
      fails++;
      $display("FAIL overrun_clear2: ovr=%b level=%0d want 0/16", overrun, level);
    end
  endtask

  task automatic test_full_push_pop();
    logic [DW-1:0] exp;
    logic [DW-1:0] d;
    out_ready = 1'b1;
    for (int i = 0; i < 41; i++) begin
      d = (i == 0) ? 8'h77 : 8'($urandom_range(0, 255));
      in_data = d; in_valid = 1'b1;
      exp = sb.pop_front();
      tests++;
      if (out_data !== exp) begin
        fails++;
        $display("FAIL pushpop_order[%0d]: got %h want %h", i, out_data, exp);
      end
      sb.push_back(d);
      step();
      tests++;
      if (level !== 5'd16 || overrun !== 1'b0) begin
        fails++;
        $display("FAIL pushpop_level[%0d]: level=%0d ovr=%b want 16/0", i, level, overrun);
      end
    end
    in_valid = 1'b0;
    drain_check("wrap_drain");
  endtask

  task automatic test_flush();
    logic [DW-1:0] exp;
    for (int i = 0; i < 5; i++) push_byte(8'h50 + 8'(i));
    tests++;
    if (level !== 5'd5) begin
      fails++;
      $display("FAIL flush_pre: level=%0d want 5", level);
    end
    in_data = 8'h33; in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    sb.delete();
    tests++;
    if (level !== 5'd0 || empty !== 1'b1 || out_valid !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL flush: level=%0d empty=%b valid=%b ovr=%b want 0/1/0/0",
               level, empty, out_valid, overrun);
    end
    push_byte(8'h44);
    exp = sb[0];
    tests++;
    if (out_data !== exp || level !== 5'd1) begin
      fails++;
      $display("FAIL flush_after: data=%h level=%0d want %h/1", out_data, level, exp);
    end
    drain_check("flush_drain");
    // flush on a full FIFO leaves an already-set overrun alone
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    in_data = 8'h99; in_valid = 1'b1;
    step();
    in_data = 8'h33; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    sb.delete();
    tests++;
    if (overrun !== 1'b1 || level !== 5'd0 || empty !== 1'b1) begin
      fails++;
      $display("FAIL flush_keeps_ovr: ovr=%b level=%0d empty=%b want 1/0/1", overrun, level, empty);
    end
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) push_byte(8'h60 + 8'(i));
    tests++;
    if (level !== 5'd7) begin
      fails++;
      $display("FAIL areset_pre: level=%0d want 7", level);
    end
    #2;
    reset_n = 1'b0;
    #1;
    sb.delete();
    tests++;
    if (level !== 5'd0 || out_valid !== 1'b0 || overrun !== 1'b0 || empty !== 1'b1) begin
      fails++;
      $display("FAIL areset: level=%0d valid=%b ovr=%b empty=%b want 0/0/0/1",
               level, out_valid, overrun, empty);
    end
    #2;
    reset_n = 1'b1;
    step();
    push_byte(8'hC3);
    drain_check("post_reset");
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_fill_drain();
    test_overrun();
    test_full_push_pop();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
